// File: rtl/ultrasonido_pkg.sv
// Shared types and constant helpers for the multichannel ultrasonic ranging engine.
package ultrasonido_pkg;

  localparam int unsigned HZ_PER_MHZ = 1_000_000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_RESULT    = 3'd4,
    ST_HOLDOFF   = 3'd5
  } state_e;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clock cycles per microsecond tick; at least one.
  function automatic int unsigned cycles_per_us(input int unsigned clk_hz);
    return (clk_hz < HZ_PER_MHZ) ? 1 : clk_hz / HZ_PER_MHZ;
  endfunction

  // Last tick index of an N-tick interval; an empty interval behaves like one tick.
  function automatic int unsigned last_tick(input int unsigned n);
    return (n == 0) ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler producing a one-cycle strobe every DIV clocks.
module us_tick_gen
  import ultrasonido_pkg::*;
#(
  parameter int unsigned DIV = 50
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int unsigned CNT_W = clog2(DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // Count 0..DIV-1 and flag the wrap.
  always_comb begin
    wrap   = (cnt_q == CNT_W'(DIV - 1));
    cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    tick_d = wrap;
  end

  // Prescaler state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/ultrasonido_multicanal.sv
// Round-robin HC-SR04 style ranging engine: triggers each sensor in turn,
// times its echo in 1 us ticks and reports the distance in centimetres.
module ultrasonido_multicanal
  import ultrasonido_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DIST_W     = 9,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned HOLDOFF_US = 60000,
  parameter int unsigned US_PER_CM  = 58
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ENABLE,
  input  logic                   MODE,
  input  logic [N_CH-1:0]        ECHO,
  output logic [N_CH-1:0]        trigg,
  output logic [DIST_W-1:0]      d,
  output logic [clog2(N_CH)-1:0] ch,
  output logic                   valid,
  output logic                   tmo,
  output logic                   busy,
  output logic                   DONE
);

  localparam int unsigned DIV     = cycles_per_us(CLK_HZ);
  localparam int unsigned CH_W    = clog2(N_CH);
  localparam int unsigned TMR_MAX = max2(max2(TIMEOUT_US, HOLDOFF_US), TRIG_US);
  localparam int unsigned TMR_W   = clog2(TMR_MAX + 1);
  localparam int unsigned SUB_W   = clog2(US_PER_CM);
  localparam int unsigned CM_MAX  = (1 << DIST_W) - 2;

  localparam logic [TMR_W-1:0]  TRIG_LAST = TMR_W'(last_tick(TRIG_US));
  localparam logic [TMR_W-1:0]  TO_LAST   = TMR_W'(last_tick(TIMEOUT_US));
  localparam logic [TMR_W-1:0]  HO_LAST   = TMR_W'(last_tick(HOLDOFF_US));
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(last_tick(US_PER_CM));
  localparam logic [DIST_W-1:0] CM_SAT    = DIST_W'(CM_MAX);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [TMR_W-1:0]   ho_q, ho_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [DIST_W-1:0]  cm_q, cm_d;
  logic               en_q;
  logic               pend_q, pend_d;
  logic [N_CH-1:0]    sync1_q, sync2_q;
  logic [N_CH-1:0]    trigg_q, trigg_d;
  logic [DIST_W-1:0]  d_q, d_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               valid_q, valid_d;
  logic               tmo_q, tmo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tick;
  logic               echo_sel;
  logic               en_rise;
  logic               start_sweep;
  logic               res_tmo;
  logic               last_ch;

  us_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign echo_sel = sync2_q[ptr_q];
  assign en_rise  = ENABLE & ~en_q;

  // Two-flop synchroniser on every echo line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ECHO;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, timers and registered-output values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tmr_d       = tmr_q;
    sub_d       = sub_q;
    cm_d        = cm_q;
    ho_d        = (tick && (ho_q != '1)) ? ho_q + TMR_W'(1) : ho_q;
    pend_d      = pend_q;
    start_sweep = 1'b0;
    res_tmo     = 1'b0;
    last_ch     = (ptr_q == CH_LAST);
    valid_d     = 1'b0;
    done_d      = 1'b0;
    d_d         = d_q;
    ch_d        = ch_q;
    tmo_d       = tmo_q;
    trigg_d     = '0;
    busy_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ENABLE && (MODE || pend_q || en_rise)) begin
          state_d     = ST_TRIG;
          ptr_d       = '0;
          start_sweep = 1'b1;
        end
      end

      ST_TRIG: begin
        if (tick) begin
          if (tmr_q == TRIG_LAST) begin
            state_d = ST_WAIT_RISE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end

      ST_WAIT_RISE: begin
        // An echo already high on entry counts as the rise.
        if (echo_sel) begin
          state_d = ST_MEASURE;
          tmr_d   = '0;
          sub_d   = '0;
          cm_d    = '0;
        end else if (tick) begin
          if (tmr_q == TO_LAST) begin
            state_d = ST_RESULT;
            res_tmo = 1'b1;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end

      ST_MEASURE: begin
        // The tick on the cycle the fall is seen still counts toward distance.
        if (tick) begin
          tmr_d = tmr_q + TMR_W'(1);
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            if (cm_q != CM_SAT) cm_d = cm_q + DIST_W'(1);
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
        if (!echo_sel) begin
          state_d = ST_RESULT;
        end else if (tick && (tmr_q == TO_LAST)) begin
          state_d = ST_RESULT;
          res_tmo = 1'b1;
        end
      end

      ST_RESULT: begin
        state_d = ST_HOLDOFF;
      end

      ST_HOLDOFF: begin
        if (tick && (ho_q >= HO_LAST)) begin
          ptr_d = last_ch ? '0 : ptr_q + CH_W'(1);
          if (ENABLE && (!last_ch || MODE)) state_d = ST_TRIG;
          else                              state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Both the phase timer and the trigger-to-trigger timer restart at TRIG entry.
    if ((state_d == ST_TRIG) && (state_q != ST_TRIG)) begin
      tmr_d = '0;
      ho_d  = '0;
    end

    pend_d = ENABLE & (pend_q | en_rise) & ~start_sweep;

    if (state_d == ST_RESULT) begin
      valid_d = 1'b1;
      ch_d    = ptr_q;
      tmo_d   = res_tmo;
      d_d     = res_tmo ? '1 : cm_d;
      done_d  = last_ch;
    end

    if (state_d == ST_TRIG) trigg_d = N_CH'(1) << ptr_d;
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      tmr_q   <= '0;
      ho_q    <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      trigg_q <= '0;
      d_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tmr_q   <= tmr_d;
      ho_q    <= ho_d;
      sub_q   <= sub_d;
      cm_q    <= cm_d;
      en_q    <= ENABLE;
      pend_q  <= pend_d;
      trigg_q <= trigg_d;
      d_q     <= d_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign trigg = trigg_q;
  assign d     = d_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign tmo   = tmo_q;
  assign busy  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_ultrasonido_multicanal.sv
// Directed bench for ultrasonido_multicanal with a behavioural echo responder.
// Timeout/holdoff are scaled down (1000/1200 us) to keep run time short.
module tb_ultrasonido_multicanal;

  localparam int unsigned TO_US = 1000;
  localparam int unsigned HO_US = 1200;

  logic       clk = 1'b0;
  logic       rst;
  logic       ENABLE;
  logic       MODE;
  logic [3:0] ECHO;
  logic [3:0] trigg;
  logic [8:0] d;
  logic [1:0] ch;
  logic       valid, tmo, busy, DONE;

  ultrasonido_multicanal #(
    .CLK_HZ(1_000_000), .N_CH(4), .DIST_W(9), .TRIG_US(10),
    .TIMEOUT_US(TO_US), .HOLDOFF_US(HO_US), .US_PER_CM(58)
  ) dut (
    .clk(clk), .rst(rst), .ENABLE(ENABLE), .MODE(MODE), .ECHO(ECHO),
    .trigg(trigg), .d(d), .ch(ch), .valid(valid), .tmo(tmo),
    .busy(busy), .DONE(DONE)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Echo responder configuration (len 0 = sensor never answers).
  int echo_dly [4];
  int echo_len [4];
  bit clr;

  // Responder state and trigger statistics.
  logic [3:0] tprev;
  int dcnt [4];
  int hcnt [4];
  bit act [4];
  int rise_cyc [4];
  int fall_cyc [4];
  int trig_rises, last_rise, min_sp, trig_run, trig_w, done_cnt, bad_onehot;

  // Sensor model plus trigger/DONE monitor, all on the falling edge.
  always @(negedge clk) begin
    if (clr) begin
      ECHO       <= 4'b0;
      trig_rises <= 0;
      last_rise  <= -1;
      min_sp     <= 1 << 30;
      trig_run   <= 0;
      trig_w     <= 0;
      done_cnt   <= 0;
      bad_onehot <= 0;
      for (int c = 0; c < 4; c++) begin
        act[c]  <= 1'b0;
        dcnt[c] <= 0;
        hcnt[c] <= 0;
      end
    end else begin
      if (DONE === 1'b1) done_cnt <= done_cnt + 1;
      if ((trigg & (trigg - 4'd1)) != 4'd0) bad_onehot <= bad_onehot + 1;
      if (trigg != 4'd0) begin
        if (tprev == 4'd0) begin
          trig_rises <= trig_rises + 1;
          if (last_rise >= 0 && (cyc - last_rise) < min_sp) min_sp <= cyc - last_rise;
          last_rise <= cyc;
          trig_run  <= 1;
        end else begin
          trig_run <= trig_run + 1;
        end
      end else if (tprev != 4'd0) begin
        trig_w <= trig_run;
      end
      for (int c = 0; c < 4; c++) begin
        if (tprev[c] && !trigg[c] && echo_len[c] > 0) begin
          act[c]  <= 1'b1;
          dcnt[c] <= echo_dly[c];
          hcnt[c] <= echo_len[c];
        end else if (act[c]) begin
          if (dcnt[c] > 0) begin
            dcnt[c] <= dcnt[c] - 1;
          end else if (hcnt[c] > 0) begin
            if (!ECHO[c]) rise_cyc[c] <= cyc;
            ECHO[c] <= 1'b1;
            hcnt[c] <= hcnt[c] - 1;
          end else begin
            ECHO[c]     <= 1'b0;
            fall_cyc[c] <= cyc;
            act[c]      <= 1'b0;
          end
        end
      end
    end
    tprev <= trigg;
  end

  logic [8:0] cap_d;
  logic [1:0] cap_ch;
  logic       cap_tmo, cap_done;
  int         cap_cyc;

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    @(posedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_echo(input int c, input int dly, input int len);
    echo_dly[c] = dly;
    echo_len[c] = len;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        ok = 1'b1; cap_d = d; cap_ch = ch; cap_tmo = tmo; cap_done = DONE; cap_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_trig(input logic [3:0] pat, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (trigg === pat) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ENABLE = 1'b0; MODE = 1'b0;
    for (int c = 0; c < 4; c++) set_echo(c, 0, 0);
    pulse_clr();
    wait_cycles(4);
    checks++; if (trigg !== 4'd0) begin errors++; $display("FAIL rst_trigg got=%b exp=0000", trigg); end
    checks++; if (d !== 9'd0)     begin errors++; $display("FAIL rst_d got=%0d exp=0", d); end
    checks++; if (ch !== 2'd0)    begin errors++; $display("FAIL rst_ch got=%0d exp=0", ch); end
    checks++; if ({valid, tmo, busy, DONE} !== 4'b0000)
      begin errors++; $display("FAIL rst_flags got=%b exp=0000", {valid, tmo, busy, DONE}); end
    rst = 1'b0;
    wait_cycles(20);
    checks++; if ({busy, trigg} !== 5'd0)
      begin errors++; $display("FAIL idle_no_enable got=%b exp=00000", {busy, trigg}); end
  endtask

  // Distance, timeout-without-rise and timeout-while-high in one single sweep.
  task automatic test_measure_and_timeouts();
    bit ok;
    int t0;
    pulse_clr();
    set_echo(0, 20, 580); set_echo(1, 0, 0); set_echo(2, 20, 1500); set_echo(3, 5, 58);
    MODE = 1'b0; ENABLE = 1'b1;
    wait_trig(4'b0001, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_trig0 got=timeout exp=0001"); end
    wait_trig(4'b0000, 40, ok);
    @(negedge clk);
    checks++; if (trig_w !== 10) begin errors++; $display("FAIL t1_trig_width got=%0d exp=10", trig_w); end
    wait_valid(2000, ok);
    checks++; if (!ok || cap_ch !== 2'd0 || cap_d !== 9'd10 || cap_tmo !== 1'b0 || cap_done !== 1'b0)
      begin errors++; $display("FAIL t1_ch0 got=ok%0d ch%0d d%0d tmo%0d done%0d exp=ok1 ch0 d10 tmo0 done0",
                               ok, cap_ch, cap_d, cap_tmo, cap_done); end
    checks++; if (cap_cyc - fall_cyc[0] !== 3)
      begin errors++; $display("FAIL t1_valid_latency got=%0d exp=3", cap_cyc - fall_cyc[0]); end
    wait_trig(4'b0010, 1300, ok);
    wait_trig(4'b0000, 40, ok);
    t0 = cyc;
    wait_valid(1100, ok);
    checks++; if (!ok || cap_ch !== 2'd1 || cap_d !== 9'h1FF || cap_tmo !== 1'b1)
      begin errors++; $display("FAIL t2_ch1_norise got=ok%0d ch%0d d%0d tmo%0d exp=ok1 ch1 d511 tmo1",
                               ok, cap_ch, cap_d, cap_tmo); end
    checks++; if (cap_cyc - t0 !== TO_US)
      begin errors++; $display("FAIL t2_wait_len got=%0d exp=%0d", cap_cyc - t0, TO_US); end
    wait_valid(2500, ok);
    checks++; if (!ok || cap_ch !== 2'd2 || cap_d !== 9'h1FF || cap_tmo !== 1'b1)
      begin errors++; $display("FAIL t3_ch2_long got=ok%0d ch%0d d%0d tmo%0d exp=ok1 ch2 d511 tmo1",
                               ok, cap_ch, cap_d, cap_tmo); end
    checks++; if (cap_cyc - rise_cyc[2] !== TO_US + 3)
      begin errors++; $display("FAIL t3_high_len got=%0d exp=%0d", cap_cyc - rise_cyc[2], TO_US + 3); end
    wait_valid(1500, ok);
    checks++; if (!ok || cap_ch !== 2'd3 || cap_d !== 9'd1 || cap_tmo !== 1'b0 || cap_done !== 1'b1)
      begin errors++; $display("FAIL t3_ch3 got=ok%0d ch%0d d%0d tmo%0d done%0d exp=ok1 ch3 d1 tmo0 done1",
                               ok, cap_ch, cap_d, cap_tmo, cap_done); end
    wait_cycles(1300);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_full_sweep();
    bit ok;
    int exp_d [4];
    exp_d[0] = 1; exp_d[1] = 2; exp_d[2] = 3; exp_d[3] = 4;
    ENABLE = 1'b0;
    wait_cycles(5);
    pulse_clr();
    for (int c = 0; c < 4; c++) set_echo(c, 10, 58 * (c + 1));
    MODE = 1'b0; ENABLE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(2000, ok);
      checks++;
      if (!ok || cap_ch !== 2'(i) || cap_d !== 9'(exp_d[i]) || cap_tmo !== 1'b0 || cap_done !== (i == 3))
        begin errors++; $display("FAIL t4_sweep%0d got=ok%0d ch%0d d%0d tmo%0d done%0d exp=ok1 ch%0d d%0d tmo0 done%0d",
                                 i, ok, cap_ch, cap_d, cap_tmo, cap_done, i, exp_d[i], (i == 3)); end
    end
    wait_cycles(1300);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_busy_end got=%b exp=0", busy); end
    wait_cycles(2000);
    checks++; if (trig_rises !== 4) begin errors++; $display("FAIL t4_no_retrigger got=%0d exp=4", trig_rises); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL t4_done_count got=%0d exp=1", done_cnt); end
    checks++; if (d !== 9'd4 || ch !== 2'd3)
      begin errors++; $display("FAIL t4_hold got=d%0d ch%0d exp=d4 ch3", d, ch); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int exp_ch [5];
    int exp_d [5];
    exp_ch[0] = 0; exp_ch[1] = 1; exp_ch[2] = 2; exp_ch[3] = 3; exp_ch[4] = 0;
    exp_d[0] = 1;  exp_d[1] = 6;  exp_d[2] = 2;  exp_d[3] = 3;  exp_d[4] = 1;
    ENABLE = 1'b0;
    wait_cycles(5);
    pulse_clr();
    set_echo(0, 10, 58); set_echo(1, 20, 400); set_echo(2, 10, 116); set_echo(3, 10, 174);
    MODE = 1'b1; ENABLE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(2000, ok);
      checks++;
      if (!ok || cap_ch !== 2'(exp_ch[i]) || cap_d !== 9'(exp_d[i]) || cap_done !== (i == 3))
        begin errors++; $display("FAIL t5_cont%0d got=ok%0d ch%0d d%0d done%0d exp=ok1 ch%0d d%0d done%0d",
                                 i, ok, cap_ch, cap_d, cap_done, exp_ch[i], exp_d[i], (i == 3)); end
    end
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (ECHO[1] === 1'b1) begin ok = 1'b1; break; end
    end
    wait_cycles(50);
    ENABLE = 1'b0;
    wait_valid(1500, ok);
    checks++; if (!ok || cap_ch !== 2'd1 || cap_d !== 9'd6 || cap_tmo !== 1'b0 || cap_done !== 1'b0)
      begin errors++; $display("FAIL t5_drop_report got=ok%0d ch%0d d%0d tmo%0d done%0d exp=ok1 ch1 d6 tmo0 done0",
                               ok, cap_ch, cap_d, cap_tmo, cap_done); end
    wait_cycles(1300);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle got=%b exp=0", busy); end
    checks++; if (trig_rises !== 6 || done_cnt !== 1)
      begin errors++; $display("FAIL t5_counts got=trig%0d done%0d exp=trig6 done1", trig_rises, done_cnt); end
    checks++; if (min_sp < HO_US)
      begin errors++; $display("FAIL t5_spacing got=%0d exp>=%0d", min_sp, HO_US); end
    checks++; if (bad_onehot !== 0)
      begin errors++; $display("FAIL t5_onehot got=%0d exp=0", bad_onehot); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulse_clr();
    for (int c = 0; c < 4; c++) set_echo(c, 10, 58);
    MODE = 1'b0; ENABLE = 1'b1;
    wait_trig(4'b0100, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t6_trig2 got=timeout exp=0100"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (trigg !== 4'd0) begin errors++; $display("FAIL t6_trig_drop got=%b exp=0000", trigg); end
    checks++; if ({d, ch, valid, tmo, busy, DONE} !== 15'd0)
      begin errors++; $display("FAIL t6_outputs got=d%0d ch%0d v%b t%b b%b D%b exp=all0",
                               d, ch, valid, tmo, busy, DONE); end
    wait_cycles(2);
    rst = 1'b0;
    wait_trig(4'b0001, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t6_restart_ch0 got=%b exp=0001", trigg); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_busy got=%b exp=1", busy); end
    ENABLE = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ENABLE = 1'b0; MODE = 1'b0; clr = 1'b1;
    test_reset();
    test_measure_and_timeouts();
    test_full_sweep();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
